// File: rtl/dma_transfer_engine.sv
// dma_transfer_engine
//   Sequencer/datapath between the DMA register file and a single-outstanding
//   memory master port. Reads beats from src, re-lanes them onto dst byte lanes
//   and writes them back, either as single read/write pairs or in buffered
//   groups of up to BURST_LEN beats.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   src_addr_i, dst_addr_i     start byte addresses
//   length_i                   beat count (0 completes with no bus traffic)
//   start_i                    level start, sampled only in IDLE
//   src_inc_i, dst_inc_i       pointer advance enables
//   burst_en_i                 group beats into BURST_LEN read-then-write bursts
//   width_i                    0 byte, 1 half, 2 word, 3 illegal
//   busy_o, done_o, error_o    status back to the register file
//   mem_*                      request/grant, response (rvalid/rdata/err) bus
module dma_transfer_engine #(
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] length_i,
  input  logic        start_i,
  input  logic        src_inc_i,
  input  logic        dst_inc_i,
  input  logic        burst_en_i,
  input  logic [1:0]  width_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR} state_e;

  function automatic logic [3:0] be_f(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'd0:    be_f = 4'b0001 << a;
      2'd1:    be_f = 4'b0011 << a;
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mask_f(input logic [1:0] w);
    case (w)
      2'd0:    mask_f = 32'h0000_00FF;
      2'd1:    mask_f = 32'h0000_FFFF;
      default: mask_f = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] step_f(input logic [1:0] w, input logic inc);
    if (!inc)            step_f = 32'd0;
    else if (w == 2'd0)  step_f = 32'd1;
    else if (w == 2'd1)  step_f = 32'd2;
    else                 step_f = 32'd4;
  endfunction

  function automatic logic misaligned_f(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'd1:    misaligned_f = a[0];
      2'd2:    misaligned_f = |a;
      default: misaligned_f = 1'b0;
    endcase
  endfunction

  state_e           state_q;
  logic [31:0]      src_q, dst_q;
  logic [15:0]      rem_q;
  logic [1:0]       width_q;
  logic             src_inc_q, dst_inc_q, burst_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      buf_q [BURST_LEN];
  logic [TMO_W-1:0] tmo_q;
  logic             req_q, we_q, busy_q, done_q, error_q;

  logic [15:0] grp_d;
  logic        last_d, tmo_hit_d, bad_d;
  logic [31:0] rd_beat_d, wr_beat_d;

  // Beats in the current group; rem_q only changes at group end so this is
  // stable for the whole read and write phase of a group.
  always_comb begin
    grp_d = 16'd1;
    if (burst_q) grp_d = (rem_q > 16'(BURST_LEN)) ? 16'(BURST_LEN) : rem_q;
  end

  assign last_d    = (16'(idx_q) == grp_d - 16'd1);
  assign tmo_hit_d = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign bad_d     = (width_i == 2'd3) || misaligned_f(width_i, src_addr_i[1:0])
                     || misaligned_f(width_i, dst_addr_i[1:0]);
  // Buffer holds beats right-aligned; lanes are re-applied on the write side.
  assign rd_beat_d = (mem_rdata_i >> {src_q[1:0], 3'b000}) & mask_f(width_q);
  assign wr_beat_d = buf_q[idx_q] << {dst_q[1:0], 3'b000};

  // Pointers only move on responses, so the bus fields are stable while req is up.
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q & we_q;
  assign mem_addr_o  = req_q ? (we_q ? dst_q : src_q) : 32'd0;
  assign mem_be_o    = req_q ? be_f(width_q, we_q ? dst_q[1:0] : src_q[1:0]) : 4'b0000;
  assign mem_wdata_o = (req_q && we_q) ? wr_beat_d : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      width_q   <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      burst_q   <= 1'b0;
      idx_q     <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) buf_q[i] <= '0;
    end else begin
      // Status pulses follow the one-cycle DONE/ERR states.
      done_q  <= (state_q == DONE);
      error_q <= (state_q == ERR);
      tmo_q   <= '0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q     <= src_addr_i;
            dst_q     <= dst_addr_i;
            rem_q     <= length_i;
            width_q   <= width_i;
            src_inc_q <= src_inc_i;
            dst_inc_q <= dst_inc_i;
            burst_q   <= burst_en_i;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (bad_d)                 state_q <= ERR;
            else if (length_i == 16'd0) state_q <= DONE;
            else begin
              state_q <= RD_REQ;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          if (mem_gnt_i) begin
            state_q <= (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
            req_q   <= 1'b0;
          end else if (tmo_hit_d) begin
            state_q <= ERR;
            req_q   <= 1'b0;
          end else tmo_q <= tmo_q + 1'b1;
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) state_q <= ERR;
            else begin
              buf_q[idx_q] <= rd_beat_d;
              src_q        <= src_q + step_f(width_q, src_inc_q);
              req_q        <= 1'b1;
              if (last_d) begin
                idx_q   <= '0;
                we_q    <= 1'b1;
                state_q <= WR_REQ;
              end else begin
                idx_q   <= idx_q + 1'b1;
                we_q    <= 1'b0;
                state_q <= RD_REQ;
              end
            end
          end else if (tmo_hit_d) state_q <= ERR;
          else tmo_q <= tmo_q + 1'b1;
        end
        WR_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) state_q <= ERR;
            else begin
              dst_q <= dst_q + step_f(width_q, dst_inc_q);
              if (last_d) begin
                idx_q <= '0;
                rem_q <= rem_q - grp_d;
                if (rem_q == grp_d) state_q <= DONE;
                else begin
                  state_q <= RD_REQ;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                end
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= WR_REQ;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
              end
            end
          end else if (tmo_hit_d) state_q <= ERR;
          else tmo_q <= tmo_q + 1'b1;
        end
        DONE, ERR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_transfer_engine.sv
// tb_dma_transfer_engine
//   Self-checking bench for dma_transfer_engine. A memory responder grants each
//   request and answers one cycle later; every granted request is compared
//   against a queue of expected bus transactions built before each transfer.
module tb_dma_transfer_engine;
  localparam int BL  = 4;
  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] length;
  logic        start, src_inc, dst_inc, burst_en;
  logic [1:0]  width;
  logic        busy, done, error;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, merr;
  logic [31:0] rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  int obs_done, obs_err, obs_rd, obs_wr, obs_req_cyc, obs_busy_cyc, obs_overlap;

  always #5 clk = ~clk;

  dma_transfer_engine #(.BURST_LEN(BL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .length_i(length),
    .start_i(start), .src_inc_i(src_inc), .dst_inc_i(dst_inc),
    .burst_en_i(burst_en), .width_i(width),
    .busy_o(busy), .done_o(done), .error_o(error),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_be_o(be),
    .mem_wdata_o(wdata), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .mem_err_i(merr)
  );

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    if (force_en) return force_val;
    return {a[7:0] + 8'h44, a[7:0] + 8'h33, a[7:0] + 8'h22, a[7:0] + 8'h11};
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [1:0] a);
    if (w == 2'd2) return 4'hF;
    return ((w == 2'd0) ? 4'h1 : 4'h3) << a;
  endfunction

  // Reference model of a whole transfer as an ordered list of bus requests.
  task automatic push_xfer(input logic [31:0] s0, input logic [31:0] d0, input int len,
                           input logic [1:0] w, input bit si, input bit di, input bit bu);
    logic [31:0] s, d, mask;
    logic [31:0] bufv [16];
    int rem, g, st;
    s = s0; d = d0; rem = len;
    st   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    mask = (w == 2'd0) ? 32'hFF : (w == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    while (rem > 0) begin
      g = bu ? ((rem < BL) ? rem : BL) : 1;
      for (int i = 0; i < g; i++) begin
        bufv[i] = (rd_value(s) >> (8 * s[1:0])) & mask;
        exp_q.push_back(txn_t'{1'b0, s, exp_be(w, s[1:0]), 32'h0});
        if (si) s = s + st;
      end
      for (int i = 0; i < g; i++) begin
        exp_q.push_back(txn_t'{1'b1, d, exp_be(w, d[1:0]), bufv[i] << (8 * d[1:0])});
        if (di) d = d + st;
      end
      rem -= g;
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                      input logic [1:0] w, input bit si, input bit di, input bit bu);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = len; width = w;
    src_inc = si; dst_inc = di; burst_en = bu; start = 1'b1;
  endtask

  // Memory responder: grants each request in its first cycle, responds the next.
  task automatic serve_bus(input int max_cyc, input int err_rd, input bit hold);
    bit pend, pwe, perr;
    logic [31:0] prd;
    int cyc, post;
    txn_t e;
    pend = 0; pwe = 0; perr = 0; prd = '0; cyc = 0; post = 0;
    obs_done = 0; obs_err = 0; obs_rd = 0; obs_wr = 0;
    obs_req_cyc = 0; obs_busy_cyc = 0; obs_overlap = 0;
    while (cyc < max_cyc && post < 4) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done)          obs_done++;
      if (error)         obs_err++;
      if (done && error) obs_overlap++;
      if (done && busy)  obs_overlap++;
      if (busy)          obs_busy_cyc++;
      if (req)           obs_req_cyc++;
      if (obs_done != 0 || obs_err != 0) post++;
      gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
      if (pend) begin
        rvalid = 1'b1;
        rdata  = pwe ? 32'h0 : prd;
        merr   = perr;
        pend   = 0;
      end else if (req && !hold) begin
        gnt = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_req: got we=%0b addr=%h be=%b, required no request", we, addr, be);
        end else begin
          e = exp_q.pop_front();
          if (we !== e.we || addr !== e.addr || be !== e.be || (e.we && wdata !== e.wdata)) begin
            n_errors++;
            $display("FAIL bus_txn: got we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                     we, addr, be, wdata, e.we, e.addr, e.be, e.wdata);
          end
        end
        pend = 1; pwe = we; perr = 0;
        if (!we) begin
          obs_rd++;
          prd = rd_value(addr);
          if (obs_rd == err_rd) perr = 1;
        end else obs_wr++;
      end
    end
    gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, error, req, we, addr, be, wdata} !== 72'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b req=%0b we=%0b addr=%h be=%b wdata=%h, required all 0",
               busy, done, error, req, we, addr, be, wdata);
    end
  endtask

  task automatic test_word_pairs();
    push_xfer(32'h100, 32'h200, 3, 2'd2, 1, 1, 0);
    kick(32'h100, 32'h200, 16'd3, 2'd2, 1, 1, 0);
    serve_bus(200, 0, 0);
    n_checks++;
    if (obs_done !== 1 || obs_err !== 0 || obs_overlap !== 0) begin
      n_errors++;
      $display("FAIL word_status: got done=%0d err=%0d overlap=%0d, required 1 0 0", obs_done, obs_err, obs_overlap);
    end
    n_checks++;
    if (obs_rd !== 3 || obs_wr !== 3 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL word_count: got rd=%0d wr=%0d left=%0d, required 3 3 0", obs_rd, obs_wr, exp_q.size());
    end
    n_checks++;
    if (obs_busy_cyc !== 13 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL word_busy: got busy_cycles=%0d busy_now=%0b, required 13 0", obs_busy_cyc, busy);
    end
  endtask

  task automatic test_byte_lanes();
    force_en = 1'b1; force_val = 32'h0000_AB00;
    exp_q.push_back(txn_t'{1'b0, 32'h101, 4'b0010, 32'h0});
    exp_q.push_back(txn_t'{1'b1, 32'h203, 4'b1000, 32'hAB00_0000});
    kick(32'h101, 32'h203, 16'd1, 2'd0, 1, 1, 0);
    serve_bus(100, 0, 0);
    force_en = 1'b0;
    n_checks++;
    if (obs_done !== 1 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL byte_done: got done=%0d left=%0d, required 1 0", obs_done, exp_q.size());
    end
  endtask

  task automatic test_burst_fixed_dst();
    push_xfer(32'h300, 32'h3F0, 6, 2'd2, 1, 0, 1);
    kick(32'h300, 32'h3F0, 16'd6, 2'd2, 1, 0, 1);
    serve_bus(200, 0, 0);
    n_checks++;
    if (obs_done !== 1 || obs_rd !== 6 || obs_wr !== 6 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL burst_done: got done=%0d rd=%0d wr=%0d left=%0d, required 1 6 6 0",
               obs_done, obs_rd, obs_wr, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    kick(32'h100, 32'h200, 16'd0, 2'd2, 1, 1, 0);
    serve_bus(50, 0, 0);
    n_checks++;
    if (obs_done !== 1 || obs_err !== 0 || obs_busy_cyc !== 1 || obs_req_cyc !== 0) begin
      n_errors++;
      $display("FAIL len_zero: got done=%0d err=%0d busy_cycles=%0d req_cycles=%0d, required 1 0 1 0",
               obs_done, obs_err, obs_busy_cyc, obs_req_cyc);
    end
  endtask

  task automatic test_misaligned();
    kick(32'h3, 32'h200, 16'd2, 2'd1, 1, 1, 0);
    serve_bus(50, 0, 0);
    n_checks++;
    if (obs_err !== 1 || obs_done !== 0 || obs_busy_cyc !== 1 || obs_req_cyc !== 0) begin
      n_errors++;
      $display("FAIL misaligned: got err=%0d done=%0d busy_cycles=%0d req_cycles=%0d, required 1 0 1 0",
               obs_err, obs_done, obs_busy_cyc, obs_req_cyc);
    end
    kick(32'h0, 32'h0, 16'd1, 2'd3, 1, 1, 0);
    serve_bus(50, 0, 0);
    n_checks++;
    if (obs_err !== 1 || obs_req_cyc !== 0) begin
      n_errors++;
      $display("FAIL width_illegal: got err=%0d req_cycles=%0d, required 1 0", obs_err, obs_req_cyc);
    end
  endtask

  task automatic test_bus_error();
    push_xfer(32'h400, 32'h480, 4, 2'd2, 1, 1, 1);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    kick(32'h400, 32'h480, 16'd4, 2'd2, 1, 1, 1);
    serve_bus(100, 2, 0);
    n_checks++;
    if (obs_err !== 1 || obs_done !== 0 || obs_wr !== 0 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL bus_error: got err=%0d done=%0d wr=%0d left=%0d, required 1 0 0 0",
               obs_err, obs_done, obs_wr, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    kick(32'h500, 32'h600, 16'd1, 2'd2, 1, 1, 0);
    serve_bus(400, 0, 1);
    n_checks++;
    if (obs_err !== 1 || obs_done !== 0 || obs_req_cyc !== TMO || req !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout: got err=%0d done=%0d req_cycles=%0d req_now=%0b, required 1 0 %0d 0",
               obs_err, obs_done, obs_req_cyc, req, TMO);
    end
  endtask

  task automatic test_reset_mid();
    kick(32'h700, 32'h780, 16'd2, 2'd2, 1, 1, 0);
    @(negedge clk); start = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk); rvalid = 1'b0; rdata = '0; gnt = 1'b1;
    n_checks++;
    if (req !== 1'b1 || we !== 1'b1 || wdata !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL midrst_wrreq: got req=%0b we=%0b wdata=%h, required 1 1 12345678", req, we, wdata);
    end
    @(negedge clk); gnt = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || req !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_wrwait: got busy=%0b req=%0b, required 1 0", busy, req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, req, we, addr, be, wdata} !== 72'h0) begin
      n_errors++;
      $display("FAIL midrst_async: got busy=%0b done=%0b err=%0b req=%0b addr=%h be=%b wdata=%h, required all 0",
               busy, done, error, req, addr, be, wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    push_xfer(32'h800, 32'h880, 2, 2'd2, 1, 1, 0);
    kick(32'h800, 32'h880, 16'd2, 2'd2, 1, 1, 0);
    serve_bus(100, 0, 0);
    n_checks++;
    if (obs_done !== 1 || obs_err !== 0 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL post_reset_xfer: got done=%0d err=%0d left=%0d, required 1 0 0", obs_done, obs_err, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    push_xfer(32'h402, 32'h500, 5, 2'd1, 1, 1, 1);
    kick(32'h402, 32'h500, 16'd5, 2'd1, 1, 1, 1);
    serve_bus(200, 0, 0);
    n_checks++;
    if (obs_done !== 1 || obs_rd !== 5 || obs_wr !== 5 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL b2b_half: got done=%0d rd=%0d wr=%0d left=%0d, required 1 5 5 0",
               obs_done, obs_rd, obs_wr, exp_q.size());
    end
    // Source pointer wraps past 2^32.
    push_xfer(32'hFFFF_FFFC, 32'h900, 2, 2'd2, 1, 0, 0);
    kick(32'hFFFF_FFFC, 32'h900, 16'd2, 2'd2, 1, 0, 0);
    serve_bus(200, 0, 0);
    n_checks++;
    if (obs_done !== 1 || exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL b2b_wrap: got done=%0d left=%0d, required 1 0", obs_done, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    src_inc = 1'b0; dst_inc = 1'b0; burst_en = 1'b0; width = '0;
    gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word_pairs();
    test_byte_lanes();
    test_burst_fixed_dst();
    test_len_zero();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
